// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch unit and a synchronous ROM.
//   imem_addr : word address presented by the fetch unit (12 bits)
//   imem_data : ROM word for the address presented in the previous cycle
// Modports:
//   master : fetch side (drives the address, receives data)
//   slave  : ROM side   (receives the address, drives data)
interface instr_fetch_if;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// Two-stage instruction fetch unit with decode of the held instruction.
// A word address is issued to a synchronous ROM, and the returned word is
// captured into IR one cycle later. In steady state the unit delivers one
// instruction per cycle. A redirect squashes the in-flight fetch and refills
// from the branch target. A stall freezes all fetch state.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   stall                 : hold all fetch state
//   branch_taken          : redirect request (wins over stall)
//   branch_target         : word address to redirect to
//   imem                  : instruction ROM bus (master side)
//   ir_valid, ir_pc       : held instruction is real / its word address
//   opcode..aluop         : 5-bit decoded fields of IR
//   imm, target           : sign-extended IR[16:0] / zero-extended IR[26:0]
//   stall_count           : saturating count of stalled cycles
module instr_fetch (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  instr_fetch_if.master        imem,
  output logic                 ir_valid,
  output logic [31:0]          ir_pc,
  output logic [4:0]           opcode,
  output logic [4:0]           rd,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           shamt,
  output logic [4:0]           aluop,
  output logic [31:0]          imm,
  output logic [31:0]          target,
  output logic [15:0]          stall_count
);

  // FILL: the ROM output does not yet belong to a fetched address.
  // RUN : the ROM output is the word for issued_pc.
  typedef enum logic {FILL, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] f_pc, f_next;
  logic [31:0] issued_pc, issued_next;
  logic [31:0] ir, ir_next;
  logic [31:0] ir_pc_next;
  logic        ir_valid_next;
  logic [31:0] ir_vis;

  // While stalled in RUN, re-present the in-flight address so the ROM
  // keeps returning the word that IR will capture once the stall lifts.
  assign imem.imem_addr = (stall && state == RUN) ? issued_pc[11:0] : f_pc[11:0];

  // NOTE: every signal gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    f_next        = f_pc;
    issued_next   = issued_pc;
    ir_next       = ir;
    ir_pc_next    = ir_pc;
    ir_valid_next = ir_valid;

    if (branch_taken) begin
      // Squash whatever is in flight and refill from the target.
      f_next        = branch_target;
      state_next    = FILL;
      ir_valid_next = 1'b0;
    end else if (!stall) begin
      issued_next = f_pc;
      f_next      = f_pc + 32'd1;
      state_next  = RUN;
      if (state == RUN) begin
        ir_next       = imem.imem_data;
        ir_pc_next    = issued_pc;
        ir_valid_next = 1'b1;
      end else begin
        ir_valid_next = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f_pc      <= '0;
      issued_pc <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
    end else begin
      f_pc      <= f_next;
      issued_pc <= issued_next;
      ir        <= ir_next;
      ir_pc     <= ir_pc_next;
      ir_valid  <= ir_valid_next;
    end
  end

  // Counts every stalled edge, including ones that also redirect.
  always_ff @(posedge clock) begin
    if (reset)                              stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

  // A bubble decodes as an all-zero instruction.
  assign ir_vis = ir_valid ? ir : '0;

  assign opcode = ir_vis[31:27];
  assign rd     = ir_vis[26:22];
  assign rs     = ir_vis[21:17];
  assign rt     = ir_vis[16:12];
  assign shamt  = ir_vis[11:7];
  assign aluop  = ir_vis[6:2];
  assign imm    = {{15{ir_vis[16]}}, ir_vis[16:0]};
  assign target = {5'd0, ir_vis[26:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A synchronous ROM model answers the
// fetch bus; each scenario task pushes the (pc, word) pairs it expects to be
// delivered, and a monitor pops and compares them whenever a new instruction
// is accepted. Scenario tasks also check latencies and boundary values inline.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ir_valid;
  logic [31:0] ir_pc;
  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm, target;
  logic [15:0] stall_count;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  bit   adv;
  exp_t exp_item;

  instr_fetch_if imem_if ();

  instr_fetch dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_if),
    .ir_valid      (ir_valid),
    .ir_pc         (ir_pc),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .rt            (rt),
    .shamt         (shamt),
    .aluop         (aluop),
    .imm           (imm),
    .target        (target),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  wire [93:0] fields = {opcode, rd, rs, rt, shamt, aluop, imm, target};

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    if (a == 12'h100)      return 32'h2884_4005;
    else if (a == 12'h101) return 32'h0001_2345;
    else                   return 32'h1000_0000 + {20'd0, a};
  endfunction

  always @(posedge clock) imem_if.imem_data <= rom_word(imem_if.imem_addr);

  // Scoreboard monitor: an edge with no reset/stall/redirect that leaves
  // ir_valid high has delivered a new instruction.
  always @(posedge clock) begin
    adv = (reset === 1'b0) && (stall === 1'b0) && (branch_taken === 1'b0);
    #1;
    if (mon_en && adv && ir_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc %h, expected no instruction", ir_pc);
      end else begin
        exp_item = exp_q.pop_front();
        if (ir_pc !== exp_item.pc || {opcode, target[26:0]} !== exp_item.word) begin
          miscompares++;
          $display("FAIL sb_instr: got pc %h ir %h, want pc %h ir %h",
                   ir_pc, {opcode, target[26:0]}, exp_item.pc, exp_item.word);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + i;
      e.word = rom_word(e.pc[11:0]);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0ABC;
    tick(); tick();
    vectors++;
    if (ir_valid !== 1'b0 || fields !== '0) begin
      miscompares++; $display("FAIL reset_fields: got valid %b fields %h, want 0", ir_valid, fields);
    end
    vectors++;
    if (imem_if.imem_addr !== 12'h000 || ir_pc !== 32'd0 || stall_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: got addr %h pc %h cnt %h, want 0", imem_if.imem_addr, ir_pc, stall_count);
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_startup();
    mon_en = 1'b1;
    push_run(32'd0, 6);
    tick();
    vectors++;
    if (ir_valid !== 1'b0 || fields !== '0) begin
      miscompares++; $display("FAIL startup_edge1: got valid %b fields %h, want 0", ir_valid, fields);
    end
    tick();
    vectors++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'd0 || opcode !== 5'd2 || target !== 32'd0) begin
      miscompares++;
      $display("FAIL startup_edge2: got valid %b pc %h op %h tgt %h, want 1 0 02 0",
               ir_valid, ir_pc, opcode, target);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (ir_pc !== k) begin
        miscompares++; $display("FAIL startup_pc: got %h want %h", ir_pc, k);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    vectors++;
    if (imem_if.imem_addr !== 12'h006) begin
      miscompares++; $display("FAIL stall_addr0: got %h want 006", imem_if.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'd5 || imem_if.imem_addr !== 12'h006) begin
        miscompares++;
        $display("FAIL stall_hold: got valid %b pc %h addr %h, want 1 5 006", ir_valid, ir_pc, imem_if.imem_addr);
      end
    end
    vectors++;
    if (stall_count !== 16'd3) begin
      miscompares++; $display("FAIL stall_count: got %0d want 3", stall_count);
    end
    stall = 1'b0;
    push_run(32'd6, 1);
    tick();
    vectors++;
    if (ir_pc !== 32'd6) begin
      miscompares++; $display("FAIL stall_release: got %h want 6", ir_pc);
    end
  endtask

  task automatic test_redirect();
    push_run(32'h40, 2);
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    vectors++;
    if (ir_valid !== 1'b0 || fields !== '0) begin
      miscompares++; $display("FAIL redirect_bubble1: got valid %b fields %h, want 0", ir_valid, fields);
    end
    vectors++;
    if (imem_if.imem_addr !== 12'h040) begin
      miscompares++; $display("FAIL redirect_addr: got %h want 040", imem_if.imem_addr);
    end
    tick();
    vectors++;
    if (ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL redirect_bubble2: got valid %b want 0", ir_valid);
    end
    tick();
    vectors++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h40) begin
      miscompares++; $display("FAIL redirect_target: got valid %b pc %h, want 1 40", ir_valid, ir_pc);
    end
    tick();
    vectors++;
    if (ir_pc !== 32'h41) begin
      miscompares++; $display("FAIL redirect_next: got %h want 41", ir_pc);
    end
  endtask

  task automatic test_branch_in_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    vectors++;
    if (ir_valid !== 1'b0 || stall_count !== 16'd4) begin
      miscompares++; $display("FAIL bstall_squash: got valid %b cnt %0d, want 0 4", ir_valid, stall_count);
    end
    tick(); tick();
    vectors++;
    if (ir_valid !== 1'b0 || imem_if.imem_addr !== 12'h080 || stall_count !== 16'd6) begin
      miscompares++;
      $display("FAIL bstall_hold: got valid %b addr %h cnt %0d, want 0 080 6", ir_valid, imem_if.imem_addr, stall_count);
    end
    push_run(32'h80, 2);
    stall = 1'b0;
    tick();
    vectors++;
    if (ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL bstall_fill: got valid %b want 0", ir_valid);
    end
    tick();
    vectors++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h80) begin
      miscompares++; $display("FAIL bstall_target: got valid %b pc %h, want 1 80", ir_valid, ir_pc);
    end
    tick();
  endtask

  task automatic test_decode();
    push_run(32'h100, 2);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    tick(); tick();
    vectors++;
    if ({opcode, rd, rs, rt, shamt, aluop} !== {5'd5, 5'd2, 5'd2, 5'd4, 5'd0, 5'd1}) begin
      miscompares++;
      $display("FAIL decode_fields: got op %0d rd %0d rs %0d rt %0d sh %0d alu %0d, want 5 2 2 4 0 1",
               opcode, rd, rs, rt, shamt, aluop);
    end
    vectors++;
    if (imm !== 32'h0000_4005 || target !== 32'h0084_4005) begin
      miscompares++; $display("FAIL decode_imm: got imm %h tgt %h, want 00004005 00844005", imm, target);
    end
    tick();
    vectors++;
    if (imm !== 32'hFFFF_2345 || opcode !== 5'd0 || rt !== 5'd18) begin
      miscompares++; $display("FAIL decode_sext: got imm %h op %0d rt %0d, want ffff2345 0 18", imm, opcode, rt);
    end
  endtask

  task automatic test_wrap();
    push_run(32'hFFFF_FFFF, 3);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    vectors++;
    if (imem_if.imem_addr !== 12'hFFF) begin
      miscompares++; $display("FAIL wrap_addr: got %h want fff", imem_if.imem_addr);
    end
    tick();
    vectors++;
    if (imem_if.imem_addr !== 12'h000) begin
      miscompares++; $display("FAIL wrap_addr_next: got %h want 000", imem_if.imem_addr);
    end
    tick();
    vectors++;
    if (ir_pc !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL wrap_pc_top: got %h want ffffffff", ir_pc);
    end
    tick();
    vectors++;
    if (ir_pc !== 32'h0000_0000) begin
      miscompares++; $display("FAIL wrap_pc_zero: got %h want 00000000", ir_pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    push_run(32'h300, 2);
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_target = 32'h300;
    tick();
    branch_taken = 1'b0;
    tick();
    vectors++;
    if (ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_bubble: got valid %b want 0", ir_valid);
    end
    tick();
    vectors++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h300) begin
      miscompares++; $display("FAIL b2b_target: got valid %b pc %h, want 1 300", ir_valid, ir_pc);
    end
    tick();
  endtask

  task automatic test_saturation_reset();
    stall = 1'b1;
    repeat (70000) tick();
    vectors++;
    if (stall_count !== 16'hFFFF || ir_pc !== 32'h301 || ir_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_count: got cnt %h pc %h valid %b, want ffff 301 1", stall_count, ir_pc, ir_valid);
    end
    reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h555;
    tick();
    vectors++;
    if (ir_valid !== 1'b0 || fields !== '0 || ir_pc !== 32'd0 || stall_count !== 16'd0 ||
        imem_if.imem_addr !== 12'h000) begin
      miscompares++;
      $display("FAIL sat_reset: got valid %b pc %h cnt %h addr %h fields %h, want all 0",
               ir_valid, ir_pc, stall_count, imem_if.imem_addr, fields);
    end
    reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    push_run(32'd0, 2);
    tick();
    vectors++;
    if (ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL sat_restart1: got valid %b want 0", ir_valid);
    end
    tick();
    vectors++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'd0) begin
      miscompares++; $display("FAIL sat_restart2: got valid %b pc %h, want 1 0", ir_valid, ir_pc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_branch_in_stall();
    test_decode();
    test_wrap();
    test_back_to_back();
    test_saturation_reset();
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: got %0d undelivered, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 The port clock SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock for all state.
REQ-003 The port reset SHALL be an input, 1 bit wide, and SHALL act as a synchronous active-high reset.
REQ-004 The port stall SHALL be an input, 1 bit wide; high holds all fetch state.
REQ-005 The port branch_taken SHALL be an input, 1 bit wide; high requests a redirect.
REQ-006 The port branch_target SHALL be an input, 32 bits wide, giving the word address for the redirect.
REQ-007 The port imem_addr SHALL be an output, 12 bits wide, driving the synchronous instruction ROM address.
REQ-008 The port imem_data SHALL be an input, 32 bits wide, carrying ROM data for the address presented in the previous cycle.
REQ-009 The port ir_valid SHALL be an output, 1 bit wide; high means the decoded fields hold a real instruction.
REQ-010 The port ir_pc SHALL be an output, 32 bits wide, giving the word address of the held instruction.
REQ-011 The port opcode SHALL be an output, 5 bits wide, equal to IR[31:27].
REQ-012 The ports rd, rs and rt SHALL be outputs, 5 bits each, equal to IR[26:22], IR[21:17] and IR[16:12].
REQ-013 The ports shamt and aluop SHALL be outputs, 5 bits each, equal to IR[11:7] and IR[6:2].
REQ-014 The port imm SHALL be an output, 32 bits wide, equal to IR[16:0] sign-extended.
REQ-015 The port target SHALL be an output, 32 bits wide, equal to IR[26:0] zero-extended.
REQ-016 The port stall_count SHALL be an output, 16 bits wide, counting stalled cycles.

Function
REQ-017 Internal state SHALL comprise: fetch PC F (32 bits), issued_pc (32 bits), IR (32 bits), ir_pc, ir_valid, a 2-state FSM {FILL, RUN}, and stall_count.
REQ-018 imem_addr SHALL equal issued_pc[11:0] when stall=1 and state=RUN, and F[11:0] otherwise; the ROM therefore re-reads the in-flight word during a stall.
REQ-019 On a normal cycle (reset=0, branch_taken=0, stall=0), issued_pc SHALL load F, F SHALL load F+1 (mod 2^32), and state SHALL become RUN.
REQ-020 On a normal cycle in RUN, IR SHALL load imem_data, ir_pc SHALL load issued_pc, and ir_valid SHALL be set to 1.
REQ-021 On a normal cycle in FILL, ir_valid SHALL be cleared to 0 and IR SHALL hold its value.
REQ-022 On a stall cycle (stall=1, branch_taken=0), F, issued_pc, IR, ir_pc, ir_valid and state SHALL all hold.
REQ-023 On a redirect (branch_taken=1), regardless of stall, F SHALL load branch_target, state SHALL become FILL, and ir_valid SHALL be cleared to 0, squashing the in-flight fetch.
REQ-024 Redirect latency: branch_taken at edge N SHALL place the target on imem_addr in cycle N+1, and the target instruction SHALL become valid (ir_valid=1, ir_pc=branch_target) at edge N+2.
REQ-025 After reset, steady-state throughput SHALL be one instruction per cycle with no stalls or redirects.
REQ-026 Decoded field outputs (opcode through target) SHALL be forced to 0 whenever ir_valid=0, so that a bubble appears as an all-zero R-type instruction.
REQ-027 stall_count SHALL increment by 1 on each edge with stall=1 and reset=0, SHALL saturate at 0xFFFF, and SHALL be unaffected by branch_taken.
REQ-028 Wrap-around: F=0xFFFFFFFF SHALL advance to 0x00000000, and imem_addr SHALL use the low 12 bits only.

Reset
REQ-029 When reset=1 at an edge, F, issued_pc, IR, ir_pc and stall_count SHALL be set to 0, ir_valid to 0, and state to FILL, with reset overriding stall and branch_taken.
REQ-030 A reset asserted mid-stream or mid-stall SHALL discard all in-flight state; the first valid instruction (ir_pc=0) SHALL appear at the second edge after reset deasserts.
REQ-031 During and immediately after reset, imem_addr SHALL be 0 and every decoded output SHALL be 0.

Verification
REQ-032 Startup: release reset with ROM[k]=0x1000_0000+k -> ir_valid=1 at edge 2 with ir_pc=0, IR=0x10000000, then ir_pc=1, 2, 3 on consecutive edges.
REQ-033 Stall: assert stall for 3 cycles while ir_pc=5 -> ir_pc stays 5, imem_addr=6 throughout, stall_count=3, and ir_pc=6 on the first edge after release.
REQ-034 Redirect: branch_taken=1 with branch_target=0x40 -> ir_valid=0 for two edges, then ir_pc=0x40, then 0x41.
REQ-035 Redirect during stall: stall=1 and branch_taken=1 with target 0x80 -> ir_valid=0, and ir_pc=0x80 appears two edges after stall drops.
REQ-036 Decode: IR=0x2884_4005 -> opcode=5, rd=2, rs=2, rt=4, shamt=0, aluop=1, imm=0x0000_4005; an instruction with IR[16]=1 SHALL yield imm[31:17] all ones.
REQ-037 Saturation and reset: hold stall for 70000 cycles -> stall_count=0xFFFF; assert reset mid-stall -> all outputs return to 0.
